bank_request_distributor: RTL and testbench

- Upstream feeder of the per-bank round-robin arbitration stage.
- Accepts read requests from NUM_RD_PORTS ports, each carrying a flat address over all banks.
- Decodes each address to bank and in-bank offset, and raises req_robin[bank][port].
- On grant, steers the winning port's offset to that bank and returns the bank read data to the requesting port.

---
 rtl/bank_distrib_pkg.sv | 34 +++
 rtl/bank_request_distributor_port_fsm.sv | 81 ++++++++
 rtl/bank_request_distributor.sv | 125 ++++++++++++
 tb/tb_bank_request_distributor.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_distrib_pkg.sv
// Shared types and the flat-address decoder for bank_request_distributor.
// Default configuration constants mirror the top-level parameter defaults.
package bank_distrib_pkg;

  localparam int DEF_NUM_BANKS    = 3;
  localparam int DEF_SIZE_BANKI   = 32;
  localparam int DEF_NUM_RD_PORTS = 8;
  localparam int DEF_DATA_W       = 32;
  localparam int BANK_IDX_W       = $clog2(DEF_NUM_BANKS);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_DATA, RESP} port_state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] bank;
    logic [31:0] offset;
  } adr_dec_t;

  // Out-of-range addresses report err with bank/offset forced to zero.
  function automatic adr_dec_t decode_adr(input logic [31:0] adr,
                                          input int unsigned size_banki,
                                          input int unsigned num_banks);
    adr_dec_t dec;
    dec = '0;
    if (adr >= size_banki * num_banks) begin
      dec.err = 1'b1;
    end else begin
      dec.bank   = adr / size_banki;
      dec.offset = adr % size_banki;
    end
    return dec;
  endfunction

endpackage

// File: rtl/bank_request_distributor_port_fsm.sv
// distrib_port_fsm: per-read-port request tracker (IDLE -> WAIT_GNT -> WAIT_DATA -> RESP).
// Handshake: a request is accepted on a clock edge where i_rd_valid && o_rd_ready.
module distrib_port_fsm
  import bank_distrib_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int SIZE_BANKI = DEF_SIZE_BANKI,
  parameter int ADR_W      = 7,
  parameter int BANK_W     = 2,
  parameter int OFF_W      = 5,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_valid,
  input  logic [ADR_W-1:0]  i_rd_adr,
  input  logic              i_gnt,
  input  logic [DATA_W-1:0] i_bank_data,
  output logic              o_rd_ready,
  output port_state_t       o_state,
  output logic [BANK_W-1:0] o_bank,
  output logic [OFF_W-1:0]  o_offset,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_resp_err
);

  port_state_t       r_state;
  port_state_t       w_state_nxt;
  logic [BANK_W-1:0] r_bank;
  logic [OFF_W-1:0]  r_offset;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  adr_dec_t          w_dec;
  logic              w_unused_dec;

  assign w_dec        = decode_adr(32'(i_rd_adr), SIZE_BANKI, NUM_BANKS);
  assign w_unused_dec = ^{w_dec.bank[31:BANK_W], w_dec.offset[31:OFF_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_bank   <= '0;
      r_offset <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && i_rd_valid) begin
        r_bank   <= w_dec.bank[BANK_W-1:0];
        r_offset <= w_dec.offset[OFF_W-1:0];
        r_err    <= w_dec.err;
        r_data   <= '0;
      end
      if (r_state == WAIT_DATA) begin
        r_data <= i_bank_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (i_rd_valid) w_state_nxt = w_dec.err ? RESP : WAIT_GNT;
      WAIT_GNT:  if (i_gnt) w_state_nxt = WAIT_DATA;
      WAIT_DATA: w_state_nxt = RESP;
      RESP:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Response fields read as zero outside the single RESP cycle.
  assign o_rd_ready   = (r_state == IDLE);
  assign o_state      = r_state;
  assign o_bank       = r_bank;
  assign o_offset     = r_offset;
  assign o_resp_valid = (r_state == RESP);
  assign o_resp_data  = (r_state == RESP) ? r_data : '0;
  assign o_resp_err   = (r_state == RESP) & r_err;

endmodule

// File: rtl/bank_request_distributor.sv
// Decodes per-port flat read addresses into per-bank arbiter requests and routes grants/data.
// Optional macro BANK_DISTRIB_CONFLICT_CNT_EN adds saturating per-bank conflict counters.
module bank_request_distributor
  import bank_distrib_pkg::*;
#(
  parameter int NUM_BANKS          = DEF_NUM_BANKS,
  parameter int SIZE_BANKI         = DEF_SIZE_BANKI,
  parameter int NUM_RD_PORTS       = DEF_NUM_RD_PORTS,
  parameter int DATA_W             = DEF_DATA_W,
  parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
  parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_RD_PORTS-1:0]                           rd_valid,
  output logic [NUM_RD_PORTS-1:0]                           rd_ready,
  input  logic [NUM_RD_PORTS-1:0][SHIRINA_VSEH_BANOK-1:0]   rd_adr,
  output logic [NUM_RD_PORTS-1:0]                           resp_valid,
  output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]               resp_data,
  output logic [NUM_RD_PORTS-1:0]                           resp_err,
  output logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]            req_robin,
  input  logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]            gnt_robin,
  output logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]           adr_raspredelyator,
  output logic [NUM_BANKS-1:0]                              bank_rd_en,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]                  bank_rd_data
`ifdef BANK_DISTRIB_CONFLICT_CNT_EN
  ,
  output logic [NUM_BANKS-1:0][15:0]                        conflict_cnt
`endif
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  port_state_t                                  w_state [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0][BANK_W-1:0]          w_bank;
  logic [NUM_RD_PORTS-1:0][SHIRINA_BANKI-1:0]   w_offset;
  logic [NUM_RD_PORTS-1:0]                      w_port_gnt;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0]          w_port_data;
  logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]       w_hit;
  logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]       w_gnt_eff;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    distrib_port_fsm #(
      .NUM_BANKS  (NUM_BANKS),
      .SIZE_BANKI (SIZE_BANKI),
      .ADR_W      (SHIRINA_VSEH_BANOK),
      .BANK_W     (BANK_W),
      .OFF_W      (SHIRINA_BANKI),
      .DATA_W     (DATA_W)
    ) u_fsm (
      .clk          (clk),
      .rst_n        (rst),
      .i_rd_valid   (rd_valid[p]),
      .i_rd_adr     (rd_adr[p]),
      .i_gnt        (w_port_gnt[p]),
      .i_bank_data  (w_port_data[p]),
      .o_rd_ready   (rd_ready[p]),
      .o_state      (w_state[p]),
      .o_bank       (w_bank[p]),
      .o_offset     (w_offset[p]),
      .o_resp_valid (resp_valid[p]),
      .o_resp_data  (resp_data[p]),
      .o_resp_err   (resp_err[p])
    );
  end

  always_comb begin
    req_robin = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_state[p] == WAIT_GNT && w_bank[p] == BANK_W'(b)) req_robin[b][p] = 1'b1;
      end
    end
  end

  // Grants to idle ports are masked off; a multi-hot grant collapses to its lowest bit.
  always_comb begin
    w_hit              = '0;
    w_gnt_eff          = '0;
    bank_rd_en         = '0;
    adr_raspredelyator = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_hit[b]      = gnt_robin[b] & req_robin[b];
      w_gnt_eff[b]  = w_hit[b] & (~w_hit[b] + NUM_RD_PORTS'(1));
      bank_rd_en[b] = |w_hit[b];
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (w_gnt_eff[b][p]) adr_raspredelyator[b] = w_offset[p];
      end
    end
  end

  always_comb begin
    w_port_gnt  = '0;
    w_port_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_bank[p] == BANK_W'(b)) begin
          w_port_gnt[p]  = w_gnt_eff[b][p];
          w_port_data[p] = bank_rd_data[b];
        end
      end
    end
  end

`ifdef BANK_DISTRIB_CONFLICT_CNT_EN
  logic [NUM_BANKS-1:0][15:0] r_conflict_cnt;

  // A bank is in conflict when two or more ports request it in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict_cnt <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (((req_robin[b] & (req_robin[b] - NUM_RD_PORTS'(1))) != '0) &&
            (r_conflict_cnt[b] != 16'hFFFF)) begin
          r_conflict_cnt[b] <= r_conflict_cnt[b] + 16'd1;
        end
      end
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_bank_request_distributor.sv
// Testbench for bank_request_distributor: vector table plus hand sequences, per-port scoreboard.
// Build with +define+BANK_DISTRIB_CONFLICT_CNT_EN to also check the conflict counters.
module tb_bank_request_distributor;

  localparam int NP = 8;
  localparam int NB = 3;

  logic                   clk;
  logic                   rst;
  logic [NP-1:0]          rd_valid;
  logic [NP-1:0]          rd_ready;
  logic [NP-1:0][6:0]     rd_adr;
  logic [NP-1:0]          resp_valid;
  logic [NP-1:0][31:0]    resp_data;
  logic [NP-1:0]          resp_err;
  logic [NB-1:0][NP-1:0]  req_robin;
  logic [NB-1:0][NP-1:0]  gnt_robin;
  logic [NB-1:0][4:0]     adr_raspredelyator;
  logic [NB-1:0]          bank_rd_en;
  logic [NB-1:0][31:0]    bank_rd_data;
`ifdef BANK_DISTRIB_CONFLICT_CNT_EN
  logic [NB-1:0][15:0]    conflict_cnt;
  logic [NB-1:0][15:0]    cc0;
`endif

  bank_request_distributor dut (
    .clk                (clk),
    .rst                (rst),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .rd_adr             (rd_adr),
    .resp_valid         (resp_valid),
    .resp_data          (resp_data),
    .resp_err           (resp_err),
    .req_robin          (req_robin),
    .gnt_robin          (gnt_robin),
    .adr_raspredelyator (adr_raspredelyator),
    .bank_rd_en         (bank_rd_en),
`ifdef BANK_DISTRIB_CONFLICT_CNT_EN
    .conflict_cnt       (conflict_cnt),
`endif
    .bank_rd_data       (bank_rd_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment models ----------------
  logic [31:0]           mem [NB][32];
  logic [NP-1:0]         blk_mask;
  logic                  multi_gnt;
  logic [NB-1:0][NP-1:0] spur_gnt;
  logic [NB-1:0][NP-1:0] arb_req;

  always_comb begin
    arb_req   = '0;
    gnt_robin = '0;
    for (int b = 0; b < NB; b++) begin
      arb_req[b]   = req_robin[b] & ~blk_mask;
      gnt_robin[b] = (multi_gnt ? arb_req[b] : (arb_req[b] & (~arb_req[b] + 8'd1))) | spur_gnt[b];
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_rd_en[b]) bank_rd_data[b] <= mem[b][adr_raspredelyator[b]];
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q [NP][$];
  int resp_cnt [NP];
  int resp_cyc [NP];
  int acc_cyc  [NP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] exp_word(input logic [6:0] adr);
    if (adr >= 7'd96) return {1'b1, 32'h0};
    return {1'b0, mem[int'(adr) / 32][int'(adr) % 32]};
  endfunction

  always @(negedge clk) begin
    logic [32:0] w;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        if (resp_valid[p]) begin
          resp_cnt[p]++;
          resp_cyc[p] = cyc;
          if (exp_q[p].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp port %0d: got resp_valid=1, expected 0", p);
          end else begin
            w = exp_q[p].pop_front();
            check($sformatf("resp port %0d {err,data}", p), {31'b0, resp_err[p], resp_data[p]}, {31'b0, w});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NP-1:0] mask, input logic [NP-1:0][6:0] adrs);
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        check($sformatf("rd_ready[%0d] before request", p), rd_ready[p], 1);
        rd_valid[p] = 1'b1;
        rd_adr[p]   = adrs[p];
        exp_q[p].push_back(exp_word(adrs[p]));
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) if (mask[p]) acc_cyc[p] = cyc;
    rd_valid = '0;
  endtask

  task automatic wait_idle(input int budget);
    int pend;
    pend = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      pend = 0;
      for (int p = 0; p < NP; p++) pend += exp_q[p].size();
      if (pend == 0) break;
    end
    check("drain pending responses", pend, 0);
  endtask

  task automatic two_port(input logic [6:0] a2, input logic [6:0] a5, input logic multi);
    logic [NP-1:0][6:0] a;
    a = '0;
    a[2] = a2;
    a[5] = a5;
    multi_gnt = multi;
    drive(8'h24, a);
    @(negedge clk);
    check("bank0 offset first", adr_raspredelyator[0], a2[4:0]);
    check("bank0 rd_en first", bank_rd_en, 3'b001);
    @(negedge clk);
    check("bank0 offset second", adr_raspredelyator[0], a5[4:0]);
    wait_idle(20);
    check("port2 latency", resp_cyc[2] - acc_cyc[2] + 1, 3);
    check("port5 latency", resp_cyc[5] - acc_cyc[5] + 1, 4);
    multi_gnt = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         port;
    logic [6:0] adr;
    int         hold;
    int         exp_lat;
  } vec_t;

  vec_t vecs [9];
  logic [NP-1:0][6:0] a_set;
  int rc3;

  initial begin
    vecs[0] = '{0, 7'd40,  0, 3};
    vecs[1] = '{7, 7'd96,  0, 1};
    vecs[2] = '{3, 7'd95,  0, 3};
    vecs[3] = '{4, 7'd127, 0, 1};
    vecs[4] = '{1, 7'd0,   0, 3};
    vecs[5] = '{1, 7'd50,  5, 8};
    vecs[6] = '{6, 7'd64,  2, 5};
    vecs[7] = '{2, 7'd31,  0, 3};
    vecs[8] = '{5, 7'd63,  0, 3};

    for (int b = 0; b < NB; b++)
      for (int o = 0; o < 32; o++) mem[b][o] = $urandom;
    mem[1][8] = 32'hDEADBEEF;
    for (int p = 0; p < NP; p++) begin
      resp_cnt[p] = 0;
      resp_cyc[p] = 0;
      acc_cyc[p]  = 0;
    end

    rst          = 1'b0;
    rd_valid     = '0;
    rd_adr       = '0;
    blk_mask     = '0;
    multi_gnt    = 1'b0;
    spur_gnt     = '0;
    bank_rd_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset resp_valid", resp_valid, 0);
    check("reset resp_err", resp_err, 0);
    check("reset resp_data", resp_data, 0);
    check("reset req_robin", req_robin, 0);
    check("reset bank_rd_en", bank_rd_en, 0);
    check("reset adr_raspredelyator", adr_raspredelyator, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rd_ready after release", rd_ready, 8'hFF);
`ifdef BANK_DISTRIB_CONFLICT_CNT_EN
    check("conflict_cnt after reset", conflict_cnt, 0);
`endif

    // immediate grant, bank 1 offset 8
    a_set = '0;
    a_set[0] = 7'd40;
    drive(8'h01, a_set);
    @(negedge clk);
    check("port0 req_robin[1][0]", req_robin[1][0], 1);
    check("port0 adr_raspredelyator[1]", adr_raspredelyator[1], 5'd8);
    check("port0 bank_rd_en", bank_rd_en, 3'b010);
    wait_idle(20);
    check("port0 latency", resp_cyc[0] - acc_cyc[0] + 1, 3);

    // out of range never requests a bank
    a_set = '0;
    a_set[7] = 7'd96;
    drive(8'h80, a_set);
    check("oor req_robin", req_robin, 0);
    wait_idle(20);
    check("oor latency", resp_cyc[7] - acc_cyc[7] + 1, 1);

    // same-bank contention, single-hot then multi-hot grants
    two_port(7'd3, 7'd17, 1'b0);
    two_port(7'd4, 7'd20, 1'b1);

    // grants to non-requesting ports
    spur_gnt[2] = 8'h10;
    #1;
    check("spurious grant bank_rd_en", bank_rd_en, 0);
    check("spurious grant offset", adr_raspredelyator[2], 0);
    spur_gnt = '0;
    spur_gnt[1] = 8'h01;
    a_set = '0;
    a_set[6] = 7'd45;
    drive(8'h40, a_set);
    @(negedge clk);
    check("spur low-index ignored offset", adr_raspredelyator[1], 5'd13);
    check("spur low-index bank_rd_en", bank_rd_en, 3'b010);
    wait_idle(20);
    spur_gnt = '0;
    check("spur port6 latency", resp_cyc[6] - acc_cyc[6] + 1, 3);

    // table vectors
    for (int i = 0; i < 9; i++) begin
      int p;
      p = vecs[i].port;
      a_set = '0;
      a_set[p] = vecs[i].adr;
      blk_mask = (vecs[i].hold > 0) ? (8'h1 << p) : 8'h0;
      drive(8'h1 << p, a_set);
      for (int k = 0; k < vecs[i].hold; k++) begin
        @(negedge clk);
        check($sformatf("vec%0d hold req_robin", i), req_robin[int'(vecs[i].adr) / 32][p], 1);
        check($sformatf("vec%0d hold rd_ready", i), rd_ready[p], 0);
        @(posedge clk);
        #1;
      end
      blk_mask = '0;
      wait_idle(40);
      check($sformatf("vec%0d latency", i), resp_cyc[p] - acc_cyc[p] + 1, vecs[i].exp_lat);
    end

    // all ports at once, one-hot grant per bank
`ifdef BANK_DISTRIB_CONFLICT_CNT_EN
    cc0 = conflict_cnt;
`endif
    a_set = '0;
    a_set[0] = 7'd0;  a_set[1] = 7'd32; a_set[2] = 7'd64; a_set[3] = 7'd1;
    a_set[4] = 7'd33; a_set[5] = 7'd65; a_set[6] = 7'd2;  a_set[7] = 7'd34;
    drive(8'hFF, a_set);
    @(negedge clk);
    check("all ports bank_rd_en", bank_rd_en, 3'b111);
    wait_idle(30);
    for (int p = 0; p < NP; p++)
      check($sformatf("all ports latency p%0d", p), resp_cyc[p] - acc_cyc[p] + 1, 3 + p / 3);
`ifdef BANK_DISTRIB_CONFLICT_CNT_EN
    check("conflict delta bank0", conflict_cnt[0] - cc0[0], 2);
    check("conflict delta bank1", conflict_cnt[1] - cc0[1], 2);
    check("conflict delta bank2", conflict_cnt[2] - cc0[2], 1);
`endif

    // reset while port 3 waits for bank data
    a_set = '0;
    a_set[3] = 7'd10;
    drive(8'h08, a_set);
    @(posedge clk);
    #1;
    rc3 = resp_cnt[3];
    rst = 1'b0;
    #1;
    check("mid reset resp_valid", resp_valid, 0);
    check("mid reset req_robin", req_robin, 0);
    check("mid reset bank_rd_en", bank_rd_en, 0);
    check("mid reset resp_data", resp_data, 0);
    check("mid reset rd_ready", rd_ready, 8'hFF);
    exp_q[3].delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("no resp after reset port3", resp_cnt[3], rc3);
    check("rd_ready[3] after reset", rd_ready[3], 1);
`ifdef BANK_DISTRIB_CONFLICT_CNT_EN
    check("conflict_cnt cleared", conflict_cnt, 0);
`endif

    wait_idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
